// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    localparam int              INSTR_W          = 32;
    localparam logic [31:0]     PC_STEP          = 32'd4;
    localparam logic [INSTR_W-1:0] NOP_INSTR     = 32'h0000_0000;
    localparam logic [31:0]     DEFAULT_RESET_PC = 32'h0000_3000;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO; flush wins over push, push+pop on a full FIFO is allowed.
module fetch_buffer #(
    parameter int DEPTH = 2,
    parameter int W     = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_r [DEPTH];
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    logic          do_pop_s;
    logic          do_push_s;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Qualify push/pop against occupancy.
    always_comb begin
        do_pop_s  = pop && (count_r != '0);
        do_push_s = push && ((count_r != CW'(DEPTH)) || do_pop_s);
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) wr_ptr_r <= next_ptr(wr_ptr_r);
            if (do_pop_s)  rd_ptr_r <= next_ptr(rd_ptr_r);
            count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
        end
    end

    // Storage array, not reset.
    always_ff @(posedge clk) begin
        if (do_push_s && !flush && !reset) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/if_fetch_checker.sv
// Protocol checks for the fetch stage's memory interface.
module if_fetch_checker #(
    parameter int CW = 2
) (
    input logic          clk,
    input logic          reset,
    input logic          imem_rvalid,
    input logic [CW-1:0] outstanding,
    input logic [CW-1:0] drop_cnt
);

    // A response with nothing in flight means the memory broke request ordering.
    a_rvalid_expected: assert property (@(posedge clk) disable iff (reset)
        imem_rvalid |-> ((outstanding != '0) || (drop_cnt != '0)));

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS IF stage: owns the PC, issues in-order imem requests, buffers responses
// and presents one instruction per cycle to IF/ID, squashing wrong-path fetches.
module if_fetch_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] IF_Instr,
    output logic [31:0]        IF_PC,
    output logic [31:0]        IF_NPC,
    output logic               if_valid
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = CW + 2;

    logic [31:0]   fetch_pc_r;
    logic [CW-1:0] outstanding_r;
    logic [CW-1:0] drop_cnt_r;
    logic [CW-1:0] buf_count_s;
    logic [CW-1:0] pcq_count_s;
    logic [31:0]   pcq_head_s;
    fetch_entry_t  buf_head_s;
    fetch_entry_t  resp_entry_s;
    fetch_entry_t  out_entry_s;
    logic [OW-1:0] occupancy_s;
    logic req_s, fire_s, rv_live_s, rv_drop_s, resp_push_s, bypass_s;
    logic valid_s, consume_s, buf_push_s, buf_pop_s, pcq_pop_s;

    // Issue, response and consume decisions. An empty buffer lets a fresh
    // response go straight to the outputs so zero-wait memory streams 1/cycle.
    always_comb begin
        occupancy_s  = OW'(outstanding_r) + OW'(drop_cnt_r) + OW'(buf_count_s);
        req_s        = !reset && !redirect_valid && (occupancy_s < OW'(DEPTH));
        fire_s       = req_s && imem_gnt;
        rv_live_s    = !reset && imem_rvalid && ((outstanding_r != '0) || (drop_cnt_r != '0));
        rv_drop_s    = rv_live_s && (drop_cnt_r != '0);
        pcq_pop_s    = rv_live_s && !rv_drop_s;
        resp_push_s  = pcq_pop_s && !redirect_valid;
        resp_entry_s = '{pc: pcq_head_s, instr: imem_rdata};
        bypass_s     = resp_push_s && (buf_count_s == '0);
        valid_s      = !reset && ((buf_count_s != '0) || bypass_s);
        consume_s    = valid_s && !stall && !redirect_valid;
        buf_push_s   = resp_push_s && !(bypass_s && consume_s);
        buf_pop_s    = consume_s && (buf_count_s != '0);
        if (buf_count_s != '0) begin
            out_entry_s = buf_head_s;
        end else begin
            out_entry_s = resp_entry_s;
        end
    end

    // IF/ID-facing outputs; a nop with zero PCs when nothing is valid.
    always_comb begin
        if (valid_s) begin
            IF_Instr = out_entry_s.instr;
            IF_PC    = out_entry_s.pc;
            IF_NPC   = out_entry_s.pc + PC_STEP;
        end else begin
            IF_Instr = NOP_INSTR;
            IF_PC    = 32'h0000_0000;
            IF_NPC   = 32'h0000_0000;
        end
    end

    assign imem_req  = req_s;
    assign imem_addr = fetch_pc_r;
    assign if_valid  = valid_s;

    // PC and in-flight accounting; a redirect turns all outstanding into drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_r    <= RESET_PC;
            outstanding_r <= '0;
            drop_cnt_r    <= '0;
        end else if (redirect_valid) begin
            fetch_pc_r    <= {redirect_pc[31:2], 2'b00};
            outstanding_r <= '0;
            drop_cnt_r    <= drop_cnt_r + outstanding_r - CW'(rv_live_s);
        end else begin
            if (fire_s) fetch_pc_r <= fetch_pc_r + PC_STEP;
            outstanding_r <= outstanding_r + CW'(fire_s) - CW'(pcq_pop_s);
            drop_cnt_r    <= drop_cnt_r - CW'(rv_drop_s);
        end
    end

    fetch_buffer #(.DEPTH(DEPTH), .W($bits(fetch_entry_t))) u_instr_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (buf_push_s),
        .push_data (resp_entry_s),
        .pop       (buf_pop_s),
        .flush     (redirect_valid),
        .head      (buf_head_s),
        .count     (buf_count_s)
    );

    fetch_buffer #(.DEPTH(DEPTH), .W(32)) u_pc_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (fire_s),
        .push_data (fetch_pc_r),
        .pop       (pcq_pop_s),
        .flush     (redirect_valid),
        .head      (pcq_head_s),
        .count     (pcq_count_s)
    );

    if_fetch_checker #(.CW(CW)) u_chk (
        .clk         (clk),
        .reset       (reset),
        .imem_rvalid (imem_rvalid),
        .outstanding (outstanding_r),
        .drop_cnt    (drop_cnt_r)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a queue-based reference model and
// an in-order memory model of configurable response latency.
module tb_if_fetch_stage;

    localparam int DEPTH = 2;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] IF_Instr;
    logic [31:0] IF_PC;
    logic [31:0] IF_NPC;
    logic        if_valid;

    if_fetch_stage dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .IF_Instr(IF_Instr), .IF_PC(IF_PC), .IF_NPC(IF_NPC), .if_valid(if_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; bit drop; } infl_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    typedef struct { int due; logic [31:0] addr; } mreq_t;

    infl_t       m_infl[$];
    ent_t        m_buf[$];
    mreq_t       mem_q[$];
    logic [31:0] m_fetch_pc;
    int          lat;
    int          cyc_n;
    int          n_checks;
    int          n_err;

    bit          e_req;
    bit          e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // Reference outputs for the current cycle from model state and inputs.
    task automatic model_eval();
        int occ;
        bit acc;
        e_req = 1'b0; e_valid = 1'b0; e_pc = 32'h0; e_instr = 32'h0;
        if (!reset) begin
            occ   = m_infl.size() + m_buf.size();
            e_req = !redirect_valid && (occ < DEPTH);
            acc   = imem_rvalid && (m_infl.size() > 0) && !m_infl[0].drop && !redirect_valid;
            if (m_buf.size() > 0) begin
                e_valid = 1'b1; e_pc = m_buf[0].pc; e_instr = m_buf[0].instr;
            end else if (acc) begin
                e_valid = 1'b1; e_pc = m_infl[0].pc; e_instr = imem_rdata;
            end
        end
    endtask

    // First half of a cycle: memory drives its response, outputs are compared.
    task automatic half();
        if (mem_q.size() > 0 && mem_q[0].due <= cyc_n) begin
            imem_rvalid = 1'b1;
            imem_rdata  = instr_of(mem_q[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
        @(negedge clk);
        model_eval();
        chk("imem_req", {31'h0, imem_req}, {31'h0, e_req});
        if (e_req) chk("imem_addr", imem_addr, m_fetch_pc);
        chk("if_valid", {31'h0, if_valid}, {31'h0, e_valid});
        chk("IF_Instr", IF_Instr, e_instr);
        chk("IF_PC", IF_PC, e_pc);
        chk("IF_NPC", IF_NPC, e_valid ? e_pc + 32'd4 : 32'h0);
    endtask

    // Second half: advance the model and memory at the clock edge.
    task automatic edge_();
        infl_t f;
        @(posedge clk);
        if (reset) begin
            m_infl.delete(); m_buf.delete(); mem_q.delete();
            m_fetch_pc = 32'h0000_3000;
        end else begin
            if (imem_rvalid && mem_q.size() > 0) void'(mem_q.pop_front());
            if (imem_rvalid && m_infl.size() > 0) begin
                f = m_infl.pop_front();
                if (!f.drop && !redirect_valid) m_buf.push_back('{f.pc, imem_rdata});
            end
            if (e_valid && !stall && !redirect_valid) void'(m_buf.pop_front());
            if (redirect_valid) begin
                foreach (m_infl[i]) m_infl[i].drop = 1'b1;
                m_buf.delete();
                m_fetch_pc = {redirect_pc[31:2], 2'b00};
            end else if (e_req && imem_gnt) begin
                m_infl.push_back('{m_fetch_pc, 1'b0});
                mem_q.push_back('{cyc_n + lat, m_fetch_pc});
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end
        cyc_n++;
        #1;
    endtask

    task automatic cyc();
        half();
        edge_();
    endtask

    task automatic do_reset(input int l);
        lat = l; reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; imem_gnt = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        reset = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_err = 0; cyc_n = 0; lat = 1;
        m_fetch_pc = 32'h0000_3000;
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;

        // Reset held three cycles, then straight-line streaming.
        for (int i = 0; i < 3; i++) begin
            half();
            chk("rst_req", {31'h0, imem_req}, 32'h0);
            chk("rst_pc", IF_PC, 32'h0);
            chk("rst_valid", {31'h0, if_valid}, 32'h0);
            edge_();
        end
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            half();
            if (k == 0) chk("first_addr", imem_addr, 32'h0000_3000);
            if (k >= 1) begin
                chk("stream_pc", IF_PC, 32'h0000_3000 + 32'(4 * (k - 1)));
                chk("stream_npc", IF_NPC, 32'h0000_3004 + 32'(4 * (k - 1)));
                chk("stream_valid", {31'h0, if_valid}, 32'h1);
            end
            edge_();
        end

        // Stall for four cycles mid-stream.
        do_reset(1);
        for (int k = 0; k < 14; k++) begin
            stall = (k >= 4 && k <= 7);
            half();
            if (k >= 4 && k <= 8) chk("stall_pc", IF_PC, 32'h0000_300C);
            if (k >= 5 && k <= 8) chk("stall_req", {31'h0, imem_req}, 32'h0);
            if (k == 9) begin
                chk("resume_pc", IF_PC, 32'h0000_3010);
                chk("resume_addr", imem_addr, 32'h0000_3014);
            end
            if (k == 10) chk("resume_pc2", IF_PC, 32'h0000_3014);
            edge_();
        end
        stall = 1'b0;

        // Grant withheld for five cycles.
        do_reset(1);
        for (int k = 0; k < 11; k++) begin
            imem_gnt = !(k >= 2 && k <= 6);
            half();
            if (k >= 2 && k <= 6) begin
                chk("nognt_req", {31'h0, imem_req}, 32'h1);
                chk("nognt_addr", imem_addr, 32'h0000_3008);
            end
            if (k == 2) chk("nognt_pc", IF_PC, 32'h0000_3004);
            if (k >= 3 && k <= 6) begin
                chk("drain_valid", {31'h0, if_valid}, 32'h0);
                chk("drain_instr", IF_Instr, 32'h0);
            end
            if (k == 8) chk("regnt_pc", IF_PC, 32'h0000_3008);
            edge_();
        end
        imem_gnt = 1'b1;

        // Redirect with two slow responses outstanding.
        do_reset(3);
        for (int k = 0; k < 13; k++) begin
            redirect_valid = (k == 2);
            redirect_pc    = 32'h0000_4000;
            half();
            if (k == 2) chk("redir_req", {31'h0, imem_req}, 32'h0);
            if (k >= 3 && k <= 6) chk("redir_drop_valid", {31'h0, if_valid}, 32'h0);
            if (k == 4) chk("redir_addr", imem_addr, 32'h0000_4000);
            if (k == 7) begin
                chk("redir_pc", IF_PC, 32'h0000_4000);
                chk("redir_valid", {31'h0, if_valid}, 32'h1);
            end
            edge_();
        end
        redirect_valid = 1'b0;

        // Redirect, stall and response in the same cycle.
        do_reset(1);
        for (int k = 0; k < 7; k++) begin
            redirect_valid = (k == 1);
            stall          = (k == 1);
            redirect_pc    = 32'h0000_5002;
            half();
            if (k == 1) begin
                chk("combo_rvalid", {31'h0, imem_rvalid}, 32'h1);
                chk("combo_req", {31'h0, imem_req}, 32'h0);
                chk("combo_valid", {31'h0, if_valid}, 32'h0);
            end
            if (k == 2) begin
                chk("combo_next_req", {31'h0, imem_req}, 32'h1);
                chk("combo_next_addr", imem_addr, 32'h0000_5000);
                chk("combo_next_valid", {31'h0, if_valid}, 32'h0);
            end
            if (k == 3) chk("combo_pc", IF_PC, 32'h0000_5000);
            edge_();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
